// File: rtl/fir_coeff_ctrl.sv
// Coefficient shadow-load and atomic bank-swap controller for the I/Q FIR, with post-swap output-valid masking.
// Latency: o_coeff_ready one cycle after i_load_start; o_swap/o_coeffs one cycle after the last beat; all outputs registered.
// Backpressure: o_coeff_ready is high only while loading; beats offered outside LOAD are dropped, never stalled.
module fir_coeff_ctrl #(
    parameter int NB_COEFF  = 16,
    parameter int NBF_COEFF = 15,
    parameter int N_COEFFS  = 17
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic                           i_load_start,
    input  logic                           i_abort,
    input  logic                           i_coeff_valid,
    input  logic signed [NB_COEFF-1:0]     i_coeff_data,
    output logic                           o_coeff_ready,
    input  logic                           i_valid,
    output logic [N_COEFFS*NB_COEFF-1:0]   o_coeffs,
    output logic                           o_swap,
    output logic                           o_out_valid,
    output logic                           o_busy,
    output logic                           o_error
);

    localparam int BANK_W = N_COEFFS * NB_COEFF;
    // Index and flush counter both need to hold N_COEFFS-1.
    localparam int IDX_W  = $clog2(N_COEFFS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFFS - 1);

    // Unity gain in Q(NBF_COEFF) placed on the centre tap: a pass-through filter.
    localparam logic [NB_COEFF-1:0] UNITY      = NB_COEFF'((2 ** NBF_COEFF) - 1);
    localparam logic [BANK_W-1:0]   IDENT_BANK = BANK_W'(UNITY) << ((N_COEFFS / 2) * NB_COEFF);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SWAP  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t                      state_q;
    logic [IDX_W-1:0]            idx_q;
    logic [IDX_W-1:0]            idx_d;
    logic [IDX_W-1:0]            flush_cnt_q;
    logic [IDX_W-1:0]            flush_cnt_d;
    logic signed [NB_COEFF-1:0]  shadow_q [N_COEFFS];
    logic [BANK_W-1:0]           shadow_pack;
    logic [BANK_W-1:0]           active_q;
    logic                        coeff_ready_q;
    logic                        swap_q;
    logic                        out_valid_q;
    logic                        busy_q;
    logic                        error_q;

    // Next write index and next flush count.
    always_comb begin
        idx_d       = idx_q + IDX_W'(1);
        flush_cnt_d = flush_cnt_q - IDX_W'(1);
    end

    // Shadow bank as it will look once the final beat lands, so the swap can
    // happen on the same edge that accepts that beat.
    always_comb begin
        shadow_pack = '0;
        for (int k = 0; k < N_COEFFS - 1; k++) begin
            shadow_pack[k*NB_COEFF +: NB_COEFF] = shadow_q[k];
        end
        shadow_pack[(N_COEFFS-1)*NB_COEFF +: NB_COEFF] = i_coeff_data;
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // Reset looks like a fresh swap: identity taps, delay line must refill.
            state_q       <= ST_FLUSH;
            flush_cnt_q   <= LAST_IDX;
            idx_q         <= '0;
            coeff_ready_q <= 1'b0;
            swap_q        <= 1'b0;
            error_q       <= 1'b0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b1;
            active_q      <= IDENT_BANK;
            for (int k = 0; k < N_COEFFS; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            swap_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_load_start) begin
                        state_q       <= ST_LOAD;
                        idx_q         <= '0;
                        coeff_ready_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (i_abort) begin
                        // Partial set is dropped; the active bank is left alone.
                        state_q       <= ST_IDLE;
                        idx_q         <= '0;
                        coeff_ready_q <= 1'b0;
                        busy_q        <= 1'b0;
                        error_q       <= 1'b1;
                    end else if (i_coeff_valid) begin
                        shadow_q[idx_q] <= i_coeff_data;
                        if (idx_q == LAST_IDX) begin
                            // Swap lands on the edge after the last beat is presented,
                            // so o_swap and o_coeffs change together.
                            state_q       <= ST_SWAP;
                            coeff_ready_q <= 1'b0;
                            swap_q        <= 1'b1;
                            active_q      <= shadow_pack;
                            out_valid_q   <= 1'b0;
                        end else begin
                            idx_q <= idx_d;
                        end
                    end
                end
                ST_SWAP: begin
                    state_q     <= ST_FLUSH;
                    flush_cnt_q <= LAST_IDX;
                end
                ST_FLUSH: begin
                    if (i_valid) begin
                        // Leave when this sample takes the counter to zero; the
                        // swap cycle already counted as the first masked sample.
                        flush_cnt_q <= flush_cnt_d;
                        if (flush_cnt_q <= IDX_W'(1)) begin
                            state_q     <= ST_IDLE;
                            flush_cnt_q <= '0;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_FLUSH;
                    flush_cnt_q <= LAST_IDX;
                    busy_q      <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_coeffs      = active_q;
    assign o_coeff_ready = coeff_ready_q;
    assign o_swap        = swap_q;
    assign o_out_valid   = out_valid_q;
    assign o_busy        = busy_q;
    assign o_error       = error_q;

endmodule
